// File: rtl/button_pkg.sv
// button_pkg: FSM state type and ms-to-cycles helper shared by the button debouncer
package button_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  // Never returns less than one cycle, so very short times still give a usable counter.
  function automatic int ms_to_cycles(input longint clock_hz, input longint ms);
    longint c;
    c = clock_hz / 1000 * ms;
    return (c < 1) ? 1 : int'(c);
  endfunction
endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous bit
// Ports: clk, reset (sync, active-high, clears to 0), d (async in), q (synchronised out)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk) begin
    if (reset) begin
      m <= 1'b0;
      q <= 1'b0;
    end else begin
      m <= d;
      q <= m;
    end
  end
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: turns a bouncy push-button into a clean level, press/release/short/long strobes and a 2-bit mode
// Ports: clk, reset (sync, active-high), btn_in (raw async, 1 = pressed),
//        btn_level (debounced level), press_pulse, release_pulse, short_pulse, long_pulse (1-cycle strobes),
//        mode (advances on every short press, wraps 3 -> 0)
module button_debouncer #(
  parameter int CLOCK_SPEED   = 100_000_000,
  parameter int DEBOUNCE_MS   = 10,
  parameter int LONG_PRESS_MS = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic [1:0] mode
);
  import button_pkg::*;
  localparam int DEB  = ms_to_cycles(CLOCK_SPEED, DEBOUNCE_MS);
  localparam int LONG = ms_to_cycles(CLOCK_SPEED, LONG_PRESS_MS);
  localparam int DW   = $clog2(DEB + 1);
  localparam int HW   = $clog2(LONG + 1);
  logic btn_s;
  state_t state, state_n;
  logic [DW-1:0] deb_cnt, deb_n;
  logic [HW-1:0] hold_cnt, hold_n, hold_inc;
  logic long_done, done_n, level_n, press_n, release_n, short_n, long_n;
  logic [1:0] mode_n;
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      long_done     <= 1'b0;
      mode          <= 2'd0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_n;
      deb_cnt       <= deb_n;
      hold_cnt      <= hold_n;
      long_done     <= done_n;
      mode          <= mode_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      short_pulse   <= short_n;
      long_pulse    <= long_n;
    end
  end
  // The debounce counter holds the number of consecutive samples already seen at the new level;
  // the transition is taken on the sample after it reaches DEB, giving 2+DEB edges of latency.
  always_comb begin
    state_n   = state;
    deb_n     = deb_cnt;
    hold_n    = hold_cnt;
    done_n    = long_done;
    mode_n    = mode;
    level_n   = btn_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    short_n   = 1'b0;
    long_n    = 1'b0;
    hold_inc  = (hold_cnt == HW'(LONG)) ? hold_cnt : hold_cnt + 1'b1;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_WAIT;
          deb_n   = DW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) state_n = IDLE;
        else if (deb_cnt == DW'(DEB)) begin
          state_n = HELD;
          press_n = 1'b1;
          level_n = 1'b1;
          hold_n  = '0;
          done_n  = 1'b0;
        end else deb_n = deb_cnt + 1'b1;
      end
      HELD: begin
        hold_n = hold_inc;
        if (hold_inc == HW'(LONG) && !long_done) begin
          long_n = 1'b1;
          done_n = 1'b1;
        end
        if (!btn_s) begin
          state_n = RELEASE_WAIT;
          deb_n   = DW'(1);
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed resumes HELD with the hold time and long flag intact.
        if (btn_s) state_n = HELD;
        else if (deb_cnt == DW'(DEB)) begin
          state_n   = IDLE;
          release_n = 1'b1;
          level_n   = 1'b0;
          short_n   = !long_done;
          mode_n    = long_done ? mode : mode + 1'b1;
        end else deb_n = deb_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: randomized and directed self-checking bench for button_debouncer
module tb_button_debouncer;
  localparam int DEB  = 1000 / 1000 * 4;
  localparam int LONG = 1000 / 1000 * 20;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, press_pulse, release_pulse, short_pulse, long_pulse;
  logic [1:0] mode;
  int checks = 0;
  int failures = 0;
  int diffs = 0;
  string first_diff = "";
  int n_press, n_release, n_short, n_long, m_n_press, m_n_release, m_n_short, m_n_long, n_overlap;
  // Reference model: a level is accepted once the synchronised input has disagreed with it
  // for DEB+1 consecutive samples; hold time accrues on samples taken while pressed and not disagreeing.
  bit m_s1, m_s2, m_level, m_done, m_press, m_release, m_short, m_long;
  int m_run, m_hold;
  bit [1:0] m_mode;
  button_debouncer #(
    .CLOCK_SPEED   (1000),
    .DEBOUNCE_MS   (4),
    .LONG_PRESS_MS (20)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse),
    .mode          (mode)
  );
  always #5 clk = ~clk;
  task automatic tick(input logic b);
    bit s;
    btn_in = b;
    @(posedge clk);
    {m_press, m_release, m_short, m_long} = 4'b0;
    if (reset) begin
      {m_s1, m_s2, m_level, m_done} = 4'b0;
      m_run = 0;
      m_hold = 0;
      m_mode = 2'd0;
    end else begin
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = b;
      if (m_level && m_run == 0) begin
        if (m_hold < LONG) m_hold++;
        if (m_hold == LONG && !m_done) begin
          m_long = 1'b1;
          m_done = 1'b1;
        end
      end
      m_run = (s != m_level) ? m_run + 1 : 0;
      if (m_run == DEB + 1) begin
        m_run = 0;
        m_level = s;
        if (s) begin
          m_press = 1'b1;
          m_hold = 0;
          m_done = 1'b0;
        end else begin
          m_release = 1'b1;
          if (!m_done) begin
            m_short = 1'b1;
            m_mode = m_mode + 2'd1;
          end
        end
      end
    end
    #1;
    n_press += int'(press_pulse);
    n_release += int'(release_pulse);
    n_short += int'(short_pulse);
    n_long += int'(long_pulse);
    m_n_press += int'(m_press);
    m_n_release += int'(m_release);
    m_n_short += int'(m_short);
    m_n_long += int'(m_long);
    if (press_pulse && release_pulse) n_overlap++;
    if ({btn_level, press_pulse, release_pulse, short_pulse, long_pulse, mode} !==
        {m_level, m_press, m_release, m_short, m_long, m_mode}) begin
      if (diffs == 0)
        first_diff = $sformatf("t=%0t got lvl/pr/rl/sh/lg/mode=%b%b%b%b%b/%0d want %b%b%b%b%b/%0d", $time,
          btn_level, press_pulse, release_pulse, short_pulse, long_pulse, mode,
          m_level, m_press, m_release, m_short, m_long, m_mode);
      diffs++;
    end
  endtask
  task automatic clear_counts();
    {n_press, n_release, n_short, n_long, n_overlap} = '0;
    {m_n_press, m_n_release, m_n_short, m_n_long} = '0;
  endtask
  task automatic model_verdict(input string name);
    checks++;
    if (diffs !== 0) begin
      failures++;
      $display("FAIL %s_model: %0d cycles differ, first: %s", name, diffs, first_diff);
    end
    diffs = 0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b0);
    checks++;
    if ({btn_level, press_pulse, release_pulse, short_pulse, long_pulse, mode} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 0000000",
        {btn_level, press_pulse, release_pulse, short_pulse, long_pulse, mode});
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick(1'b0);
    checks++;
    if ({btn_level, press_pulse, release_pulse, short_pulse, long_pulse, mode} !== 7'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got %b want 0000000",
        {btn_level, press_pulse, release_pulse, short_pulse, long_pulse, mode});
    end
    model_verdict("reset");
  endtask
  task automatic test_glitch();
    clear_counts();
    for (int i = 0; i < 3; i++) tick(1'b1);
    for (int i = 0; i < 12; i++) tick(1'b0);
    checks++;
    if (n_press !== 0 || btn_level !== 1'b0 || mode !== 2'd0) begin
      failures++;
      $display("FAIL glitch_reject: presses=%0d level=%b mode=%0d want 0 0 0", n_press, btn_level, mode);
    end
    model_verdict("glitch");
  endtask
  task automatic test_short_press();
    int pi = -1, ri = -1, si = -1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1);
      if (press_pulse && pi < 0) pi = i;
    end
    checks++;
    if (pi !== 2 + DEB) begin
      failures++;
      $display("FAIL press_latency: got edge %0d want %0d", pi, 2 + DEB);
    end
    checks++;
    if (btn_level !== 1'b1) begin
      failures++;
      $display("FAIL press_level: got %b want 1", btn_level);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b0);
      if (release_pulse && ri < 0) ri = i;
      if (short_pulse && si < 0) si = i;
    end
    checks++;
    if (ri !== 2 + DEB || si !== 2 + DEB) begin
      failures++;
      $display("FAIL release_short_latency: got release %0d short %0d want %0d", ri, si, 2 + DEB);
    end
    checks++;
    if (mode !== 2'd1 || btn_level !== 1'b0) begin
      failures++;
      $display("FAIL short_mode: got mode %0d level %b want 1 0", mode, btn_level);
    end
    model_verdict("short_press");
  endtask
  task automatic test_long_press();
    int pi = -1, li = -1;
    clear_counts();
    for (int i = 0; i < 40; i++) begin
      tick(1'b1);
      if (press_pulse && pi < 0) pi = i;
      if (long_pulse && li < 0) li = i;
    end
    checks++;
    if (li - pi !== LONG || n_long !== 1) begin
      failures++;
      $display("FAIL long_timing: got press %0d long %0d count %0d want gap %0d count 1", pi, li, n_long, LONG);
    end
    for (int i = 0; i < 12; i++) tick(1'b0);
    checks++;
    if (n_release !== 1 || n_short !== 0 || mode !== 2'd1) begin
      failures++;
      $display("FAIL long_release: got releases %0d shorts %0d mode %0d want 1 0 1", n_release, n_short, mode);
    end
    model_verdict("long_press");
  endtask
  task automatic test_bounce_and_cycle();
    bit [1:0] want [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    clear_counts();
    for (int i = 0; i < 10; i++) tick(1'b1);
    for (int i = 0; i < 2; i++) tick(1'b0);
    tick(1'b1);
    for (int i = 0; i < 15; i++) tick(1'b0);
    checks++;
    if (n_release !== 1 || n_short !== 1 || mode !== 2'd2) begin
      failures++;
      $display("FAIL bounce_release: got releases %0d shorts %0d mode %0d want 1 1 2", n_release, n_short, mode);
    end
    reset = 1'b1;
    tick(1'b0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 10; i++) tick(1'b1);
      for (int i = 0; i < 10; i++) tick(1'b0);
      checks++;
      if (mode !== want[k]) begin
        failures++;
        $display("FAIL mode_cycle_%0d: got %0d want %0d", k, mode, want[k]);
      end
    end
    model_verdict("bounce_cycle");
  endtask
  task automatic test_reset_held();
    for (int i = 0; i < 10; i++) tick(1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1);
    checks++;
    if (btn_level !== 1'b1 || mode !== 2'd1) begin
      failures++;
      $display("FAIL held_before_reset: got level %b mode %0d want 1 1", btn_level, mode);
    end
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    checks++;
    if (btn_level !== 1'b0 || mode !== 2'd0) begin
      failures++;
      $display("FAIL reset_in_held: got level %b mode %0d want 0 0", btn_level, mode);
    end
    clear_counts();
    for (int i = 0; i < 15; i++) tick(1'b0);
    checks++;
    if (n_release !== 0 || n_short !== 0 || n_press !== 0) begin
      failures++;
      $display("FAIL reset_no_pulse: got releases %0d shorts %0d presses %0d want 0 0 0", n_release, n_short, n_press);
    end
    model_verdict("reset_held");
  endtask
  task automatic test_random();
    clear_counts();
    for (int k = 0; k < 160; k++) begin
      logic v;
      int len;
      v = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 60) : $urandom_range(1, 8);
      reset = ($urandom_range(0, 39) == 0);
      tick(v);
      reset = 1'b0;
      for (int i = 1; i < len; i++) tick(v);
    end
    for (int i = 0; i < 12; i++) tick(1'b0);
    checks++;
    if ({n_press, n_release, n_short, n_long} !== {m_n_press, m_n_release, m_n_short, m_n_long}) begin
      failures++;
      $display("FAIL random_counts: got p/r/s/l %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
        n_press, n_release, n_short, n_long, m_n_press, m_n_release, m_n_short, m_n_long);
    end
    checks++;
    if (n_overlap !== 0) begin
      failures++;
      $display("FAIL press_release_overlap: got %0d want 0", n_overlap);
    end
    model_verdict("random");
  endtask
  initial begin
    clear_counts();
    test_reset();
    test_glitch();
    test_short_press();
    test_long_press();
    test_bounce_and_cycle();
    test_reset_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
